// File: rtl/mac_ctrl_pkg.sv
// Shared sizing constants and FSM state encoding for the MAC job arbiter.
package mac_ctrl_pkg;

    localparam int M                  = 4;
    localparam int K                  = 4;
    localparam int N                  = 4;
    localparam int DATA_WIDTH_INITIAL = 8;
    localparam int DATA_WIDTH_FINAL   = DATA_WIDTH_INITIAL * 2;
    localparam int TIMEOUT_CYCLES     = 1024;

    // Flattened bus widths for the operand and result matrices.
    localparam int A_W  = M * K * DATA_WIDTH_INITIAL;
    localparam int B_W  = K * N * DATA_WIDTH_INITIAL;
    localparam int C_W  = M * N * DATA_WIDTH_FINAL;
    // Watchdog counter width, wide enough to hold TIMEOUT_CYCLES.
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        WAIT_DONE,
        SETTLE,
        READ,
        CAPTURE,
        RESP
    } state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter. On a tie the requester that was not granted
// last wins. The last-grant pointer moves only when a grant is taken.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       grant_en_i,
    output logic       grant_o,
    output logic       any_o
);

    logic last_q;
    logic last_d;

    // Grant selection and pointer next-state.
    always_comb begin
        any_o   = |req_i;
        grant_o = 1'b0;
        if (req_i == 2'b11) begin
            grant_o = ~last_q;
        end else if (req_i[1]) begin
            grant_o = 1'b1;
        end
        last_d = last_q;
        if (grant_en_i && any_o) begin
            last_d = grant_o;
        end
    end

    // Pointer resets to requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mac_job_arbiter.sv
// Arbitrates matrix-multiply jobs from two requesters onto a single MAC,
// sequencing operand load, completion wait, result read and response.
// Handshakes: a job transfers in the IDLE cycle where req_rdy pulses; a
// response transfers on the cycle rsp_val and rsp_rdy of the granted
// requester are both high; host2block_val waits for host2block_rdy and is
// never withdrawn once raised, except by reset.
module mac_job_arbiter
    import mac_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_val,
    output logic [1:0]           req_rdy,
    input  logic [1:0][A_W-1:0]  req_a_data,
    input  logic [1:0][B_W-1:0]  req_b_data,
    output logic [1:0]           rsp_val,
    input  logic [1:0]           rsp_rdy,
    output logic [C_W-1:0]       rsp_c_data,
    output logic                 rsp_err,
    output logic                 host2block_val,
    input  logic                 host2block_rdy,
    output logic [A_W-1:0]       a_data_in_ext,
    output logic [B_W-1:0]       b_data_in_ext,
    output logic                 a_b_we_ext,
    input  logic                 mac_done,
    input  logic                 block2host_val,
    output logic                 block2host_rdy,
    output logic                 c_re_ext,
    input  logic [C_W-1:0]       c_data_out_ext
);

    state_e          state_q, state_d;
    logic            grant_q, grant_d;
    logic [A_W-1:0]  a_q, a_d;
    logic [B_W-1:0]  b_q, b_d;
    logic [C_W-1:0]  c_q, c_d;
    logic            err_q, err_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            arb_grant;
    logic            arb_any;
    logic            unused_b2h_val;

    // block2host_val is informational; the FSM paces the read itself.
    assign unused_b2h_val = block2host_val;

    assign rsp_c_data = c_q;
    assign rsp_err    = err_q;

    rr_arbiter_2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_val),
        .grant_en_i (state_q == IDLE),
        .grant_o    (arb_grant),
        .any_o      (arb_any)
    );

    // Next-state, datapath next values and all combinational outputs.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        a_d            = a_q;
        b_d            = b_q;
        c_d            = c_q;
        err_d          = err_q;
        wd_d           = '0;
        req_rdy        = 2'b00;
        rsp_val        = 2'b00;
        host2block_val = 1'b0;
        a_b_we_ext     = 1'b0;
        a_data_in_ext  = '0;
        b_data_in_ext  = '0;
        block2host_rdy = 1'b0;
        c_re_ext       = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by rst so req_rdy stays low while reset is held.
                if (arb_any && !rst) begin
                    req_rdy[arb_grant] = 1'b1;
                    grant_d            = arb_grant;
                    a_d                = req_a_data[arb_grant];
                    b_d                = req_b_data[arb_grant];
                    err_d              = 1'b0;
                    state_d            = LOAD;
                end
            end
            LOAD: begin
                host2block_val = 1'b1;
                if (host2block_rdy) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                host2block_val = 1'b1;
                a_b_we_ext     = 1'b1;
                a_data_in_ext  = a_q;
                b_data_in_ext  = b_q;
                state_d        = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (mac_done) begin
                    state_d = SETTLE;
                end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    c_d     = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            SETTLE: begin
                state_d = READ;
            end
            READ: begin
                block2host_rdy = 1'b1;
                c_re_ext       = 1'b1;
                state_d        = CAPTURE;
            end
            CAPTURE: begin
                c_d     = c_data_out_ext;
                state_d = RESP;
            end
            RESP: begin
                rsp_val[grant_q] = 1'b1;
                if (rsp_rdy[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched operands, result, error flag and watchdog registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_mac_job_arbiter.sv
// Directed bench for mac_job_arbiter with a behavioural MAC model.
module tb_mac_job_arbiter;
    import mac_ctrl_pkg::*;

    localparam int DWI = DATA_WIDTH_INITIAL;
    localparam int DWF = DATA_WIDTH_FINAL;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [1:0]          req_val;
    logic [1:0]          req_rdy;
    logic [1:0][A_W-1:0] req_a_data;
    logic [1:0][B_W-1:0] req_b_data;
    logic [1:0]          rsp_val;
    logic [1:0]          rsp_rdy;
    logic [C_W-1:0]      rsp_c_data;
    logic                rsp_err;
    logic                host2block_val;
    logic                host2block_rdy;
    logic [A_W-1:0]      a_data_in_ext;
    logic [B_W-1:0]      b_data_in_ext;
    logic                a_b_we_ext;
    logic                mac_done;
    logic                block2host_val;
    logic                block2host_rdy;
    logic                c_re_ext;
    logic [C_W-1:0]      c_data_out_ext;

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    mac_job_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .req_val        (req_val),
        .req_rdy        (req_rdy),
        .req_a_data     (req_a_data),
        .req_b_data     (req_b_data),
        .rsp_val        (rsp_val),
        .rsp_rdy        (rsp_rdy),
        .rsp_c_data     (rsp_c_data),
        .rsp_err        (rsp_err),
        .host2block_val (host2block_val),
        .host2block_rdy (host2block_rdy),
        .a_data_in_ext  (a_data_in_ext),
        .b_data_in_ext  (b_data_in_ext),
        .a_b_we_ext     (a_b_we_ext),
        .mac_done       (mac_done),
        .block2host_val (block2host_val),
        .block2host_rdy (block2host_rdy),
        .c_re_ext       (c_re_ext),
        .c_data_out_ext (c_data_out_ext)
    );

    logic [520:0] all_outs;
    assign all_outs = {req_rdy, rsp_val, rsp_c_data, rsp_err, host2block_val,
                       a_data_in_ext, b_data_in_ext, a_b_we_ext,
                       block2host_rdy, c_re_ext};

    // ---------------- MAC model ----------------
    function automatic logic [C_W-1:0] matmul(input logic [A_W-1:0] a, input logic [B_W-1:0] bt);
        logic [C_W-1:0] res;
        int             acc;
        res = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int k = 0; k < K; k++) begin
                    acc += int'(a[(i*K+k)*DWI +: DWI]) * int'(bt[(j*K+k)*DWI +: DWI]);
                end
                res[(i*N+j)*DWF +: DWF] = DWF'(acc);
            end
        end
        return res;
    endfunction

    int             mac_lat  = 0;
    bit             mac_hang = 1'b0;
    logic           busy;
    int             cnt;
    logic [A_W-1:0] cap_a;
    logic [B_W-1:0] cap_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy           <= 1'b0;
            cnt            <= 0;
            mac_done       <= 1'b0;
            block2host_val <= 1'b0;
            c_data_out_ext <= '0;
        end else begin
            mac_done       <= 1'b0;
            block2host_val <= 1'b0;
            if (a_b_we_ext) begin
                cap_a <= a_data_in_ext;
                cap_b <= b_data_in_ext;
                busy  <= 1'b1;
                cnt   <= 0;
            end else if (busy && !mac_hang) begin
                if (cnt == mac_lat) begin
                    mac_done       <= 1'b1;
                    block2host_val <= 1'b1;
                    busy           <= 1'b0;
                    c_data_out_ext <= matmul(cap_a, cap_b);
                end else begin
                    cnt <= cnt + 1;
                end
            end
        end
    end

    // ---------------- event monitor ----------------
    int rdy0_cnt  = 0;
    int rdy1_cnt  = 0;
    int we_cnt    = 0;
    int op_bad    = 0;
    int stall_cnt = 0;
    int mon_g     = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (req_rdy[0]) begin rdy0_cnt++; mon_g = 0; end
            if (req_rdy[1]) begin rdy1_cnt++; mon_g = 1; end
            if (a_b_we_ext) begin
                we_cnt++;
                if (a_data_in_ext !== req_a_data[mon_g] || b_data_in_ext !== req_b_data[mon_g]) op_bad++;
            end else if (a_data_in_ext !== '0 || b_data_in_ext !== '0) begin
                op_bad++;
            end
            if (host2block_val && !host2block_rdy) stall_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input int r, output bit ok);
        ok = 1'b0;
        req_val[r] = 1'b1;
        #1;
        for (int i = 0; i < 50; i++) begin
            if (req_rdy[r]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        req_val[r] = 1'b0;
    endtask

    task automatic wait_rsp(input int r, input int limit, output int n);
        n = 0;
        while (!rsp_val[r] && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic finish_rsp(input int r);
        rsp_rdy[r] = 1'b1;
        tick();
        rsp_rdy[r] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [A_W-1:0] a0, a1, a2;
    logic [B_W-1:0] bt0, bt1, bt2;
    logic [C_W-1:0] c8;
    int             g[4];
    int             ng, n, base0, base1, base_we, base_st, bad;
    bit             ok;

    initial begin
        req_val        = 2'b00;
        rsp_rdy        = 2'b00;
        host2block_rdy = 1'b1;
        req_a_data     = '0;
        req_b_data     = '0;
        for (int i = 0; i < M*K; i++) begin
            a0[i*DWI +: DWI] = DWI'(i);
            a1[i*DWI +: DWI] = DWI'(1);
            a2[i*DWI +: DWI] = DWI'(i);
        end
        for (int j = 0; j < N; j++) begin
            for (int k = 0; k < K; k++) begin
                bt0[(j*K+k)*DWI +: DWI] = DWI'(k*N + j);
                bt1[(j*K+k)*DWI +: DWI] = DWI'(2);
                bt2[(j*K+k)*DWI +: DWI] = (j == k) ? DWI'(1) : DWI'(0);
            end
        end
        for (int i = 0; i < M*N; i++) c8[i*DWF +: DWF] = DWF'(8);
        req_a_data[0] = a0;  req_b_data[0] = bt0;
        req_a_data[1] = a1;  req_b_data[1] = bt1;

        // Reset
        #1 rst = 1'b1;
        repeat (3) tick();
        chk("reset_outputs_zero", all_outs, 0);
        rst = 1'b0;
        tick();

        // Single job, requester 0
        base0 = rdy0_cnt; base_we = we_cnt;
        start_job(0, ok);
        chk("single_granted", ok, 1);
        wait_rsp(0, 100, n);
        chk("single_latency", n, 7);
        chk("single_rsp_val", rsp_val, 2'b01);
        chk("single_c0", rsp_c_data[0 +: DWF], 56);
        chk("single_c15", rsp_c_data[15*DWF +: DWF], 506);
        chk("single_err", rsp_err, 0);
        finish_rsp(0);
        chk("single_rsp_val_drop", rsp_val, 2'b00);
        chk("single_rdy_pulses", rdy0_cnt - base0, 1);
        chk("single_we_pulses", we_cnt - base_we, 1);

        // Tie from reset: both requesters always requesting
        mac_lat = 2;
        rst = 1'b1;
        req_val = 2'b11;
        rsp_rdy = 2'b11;
        #1;
        chk("reset_gates_outputs", all_outs, 0);
        tick();
        rst = 1'b0;
        #1;
        base0 = rdy0_cnt; base1 = rdy1_cnt;
        ng = 0;
        g = '{-1, -1, -1, -1};
        for (int c = 0; c < 400; c++) begin
            if (req_rdy[0]) begin g[ng] = 0; ng++; end
            else if (req_rdy[1]) begin g[ng] = 1; ng++; end
            if (ng == 4) break;
            tick();
        end
        tick();
        req_val = 2'b00;
        wait_rsp(1, 100, n);
        chk("tie_last_rsp_val", rsp_val, 2'b10);
        chk("tie_last_data", rsp_c_data, c8);
        tick();
        rsp_rdy = 2'b00;
        chk("tie_grant_count", ng, 4);
        chk("tie_order0", g[0], 0);
        chk("tie_order1", g[1], 1);
        chk("tie_order2", g[2], 0);
        chk("tie_order3", g[3], 1);
        chk("tie_rdy0_pulses", rdy0_cnt - base0, 2);
        chk("tie_rdy1_pulses", rdy1_cnt - base1, 2);

        // Response stall on requester 1, requester 0 waiting
        mac_lat = 1;
        base0 = rdy0_cnt;
        start_job(1, ok);
        chk("stall_granted1", ok, 1);
        req_val[0] = 1'b1;
        rsp_rdy[0] = 1'b1;
        wait_rsp(1, 100, n);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_val !== 2'b10 || rsp_c_data !== c8 || req_rdy !== 2'b00) bad++;
            if (i < 19) tick();
        end
        chk("stall_stable_20", bad, 0);
        chk("stall_no_grant0", rdy0_cnt - base0, 0);
        rsp_rdy[1] = 1'b1;
        tick();
        rsp_rdy[1] = 1'b0;
        chk("stall_then_grant0", req_rdy, 2'b01);
        chk("stall_rsp_val_drop", rsp_val, 2'b00);
        tick();
        req_val[0] = 1'b0;
        wait_rsp(0, 100, n);
        chk("stall_job0_c0", rsp_c_data[0 +: DWF], 56);
        tick();
        rsp_rdy = 2'b00;

        // Backpressure on host2block_rdy
        mac_lat = 3;
        host2block_rdy = 1'b0;
        base_st = stall_cnt; base_we = we_cnt;
        start_job(0, ok);
        n = 0;
        while (n < 200) begin
            if (n == 7) host2block_rdy = 1'b1;
            if (rsp_val[0]) break;
            tick();
            n++;
        end
        chk("bp_latency", n, 17);
        chk("bp_stall_cycles", stall_cnt - base_st, 7);
        chk("bp_we_pulses", we_cnt - base_we, 1);
        chk("bp_c15", rsp_c_data[15*DWF +: DWF], 506);
        finish_rsp(0);

        // Watchdog timeout
        mac_hang = 1'b1;
        start_job(0, ok);
        n = 0;
        while (!a_b_we_ext && n < 20) begin tick(); n++; end
        wait_rsp(0, 1100, n);
        chk("to_latency", n, 1025);
        chk("to_rsp_val", rsp_val, 2'b01);
        chk("to_err", rsp_err, 1);
        chk("to_data_zero", rsp_c_data, 0);
        finish_rsp(0);
        chk("to_err_held_idle", rsp_err, 1);

        // Reset mid-job in WAIT_DONE
        start_job(1, ok);
        chk("err_clear_on_load", rsp_err, 0);
        n = 0;
        while (!a_b_we_ext && n < 20) begin tick(); n++; end
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("midrst_outputs_zero", all_outs, 0);
        tick();
        rst = 1'b0;
        mac_hang = 1'b0;
        mac_lat = 0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (rsp_val !== 2'b00) bad++;
            tick();
        end
        chk("midrst_no_rsp", bad, 0);
        req_a_data[0] = a2; req_b_data[0] = bt2;
        start_job(0, ok);
        chk("post_rst_granted", ok, 1);
        wait_rsp(0, 100, n);
        chk("post_rst_latency", n, 7);
        chk("post_rst_c6", rsp_c_data[6*DWF +: DWF], 6);
        chk("post_rst_c15", rsp_c_data[15*DWF +: DWF], 15);
        chk("post_rst_err", rsp_err, 0);
        finish_rsp(0);
        chk("operand_bus_clean", op_bad, 0);

        // Report
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/mac_job_arbiter.md
MAC_JOB_ARBITER -- requirements
Module: mac_job_arbiter

Interface
REQ-001 Params: M=4 (rows of A), K=4 (inner dim), N=4 (cols of B), DATA_WIDTH_INITIAL=8 (operand bits), DATA_WIDTH_FINAL=DATA_WIDTH_INITIAL*2 (result element bits), TIMEOUT_CYCLES=1024 (mac_done watchdog limit).
REQ-002 Ports, in order:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_val  in  2  per-requester job valid.
- req_rdy  out  2  per-requester job accept, one-cycle pulse.
- req_a_data  in  2 x M*K x DATA_WIDTH_INITIAL  per-requester matrix A, row-major.
- req_b_data  in  2 x K*N x DATA_WIDTH_INITIAL  per-requester matrix B, pre-transposed.
- rsp_val  out  2  per-requester result valid.
- rsp_rdy  in  2  per-requester result accept.
- rsp_c_data  out  M*N*DATA_WIDTH_FINAL  shared result bus.
- rsp_err  out  1  set when the response is a timeout.
- host2block_val  out  1  job offer to the MAC.
- host2block_rdy  in  1  MAC ready for operands.
- a_data_in_ext  out  M*K*DATA_WIDTH_INITIAL  A to the MAC.
- b_data_in_ext  out  K*N*DATA_WIDTH_INITIAL  B to the MAC.
- a_b_we_ext  out  1  operand write enable.
- mac_done  in  1  MAC computation complete.
- block2host_val  in  1  MAC result valid (informational).
- block2host_rdy  out  1  result read handshake.
- c_re_ext  out  1  result read enable.
- c_data_out_ext  in  M*N*DATA_WIDTH_FINAL  result from the MAC.

Function
REQ-003 The FSM SHALL use these states: IDLE, LOAD, WRITE, WAIT_DONE, SETTLE, READ, CAPTURE, RESP.
REQ-004 IDLE: if any req_val is high, the block SHALL grant round-robin (the requester not last granted wins a tie), pulse req_rdy[grant] for that cycle, latch that requester's A/B into internal registers, and go to LOAD.
REQ-005 LOAD SHALL assert host2block_val and go to WRITE on the first cycle host2block_rdy is sampled high.
REQ-006 WRITE SHALL last exactly one cycle with host2block_val=1, a_b_we_ext=1 and the latched A/B driven; it then goes to WAIT_DONE.
REQ-007 Outside WRITE, a_data_in_ext and b_data_in_ext SHALL be zero.
REQ-008 WAIT_DONE SHALL go to SETTLE when mac_done=1; SETTLE SHALL last exactly one cycle and then go to READ.
REQ-009 READ SHALL last one cycle with block2host_rdy=1 and c_re_ext=1; CAPTURE SHALL register c_data_out_ext into rsp_c_data and then go to RESP.
REQ-010 RESP SHALL hold rsp_val[grant]=1 and rsp_c_data stable until rsp_rdy[grant]=1, then return to IDLE the next cycle; rsp_rdy of the non-granted requester SHALL be ignored.
REQ-011 A watchdog SHALL count cycles in WAIT_DONE; when it reaches TIMEOUT_CYCLES it SHALL force rsp_c_data=0 and rsp_err=1 and go to RESP.
REQ-012 rsp_err SHALL clear on entry to LOAD.
REQ-013 Only one job SHALL be in flight; req_rdy SHALL stay 0 outside IDLE, and req_val changes mid-job SHALL have no effect.
REQ-014 The last-granted pointer SHALL update only on grant.
REQ-015 Latency from grant to rsp_val SHALL be (cycles in LOAD) + 1 + (cycles in WAIT_DONE) + 3, with no extra bubbles.
REQ-016 No arithmetic SHALL be done on data; all widths pass through unchanged.

Reset
REQ-017 On rst high (asynchronous), the state SHALL be IDLE and every output SHALL be 0, including rsp_c_data and rsp_err.
REQ-018 On rst, the last-grant pointer SHALL select requester 1, so requester 0 wins the first tie, and the watchdog SHALL clear.
REQ-019 rst asserted mid-job SHALL abandon the job with no response; the MAC side sees host2block_val, a_b_we_ext, block2host_rdy and c_re_ext deasserted immediately.

Structure
REQ-020 Package mac_ctrl_pkg SHALL hold M, K, N, DATA_WIDTH_INITIAL, DATA_WIDTH_FINAL, TIMEOUT_CYCLES and the state enum typedef.
REQ-021 One sub-module, rr_arbiter_2, SHALL hold the 2-way round-robin grant logic and pointer; the FSM, operand registers and watchdog SHALL stay in the top.

Verification
REQ-022 Single job: requester 0 sends A[i]=i and B = transpose of B[i]=i, with the mac_top model -> one req_rdy[0] pulse, one a_b_we_ext pulse, rsp_val[0] with C[0]=56 and C[15]=506.
REQ-023 Tie: both req_val high from reset -> requester 0 served first, then requester 1; grant order 0,1,0,1 over 4 jobs.
REQ-024 Backpressure: host2block_rdy held low 7 cycles -> LOAD holds host2block_val for 7 cycles, WRITE occurs once, data unchanged.
REQ-025 Response stall: rsp_rdy[1] low 20 cycles -> rsp_val[1] and rsp_c_data stable for 20 cycles; requester 0 is not granted until the handshake completes.
REQ-026 Timeout: mac_done never asserts -> after 1024 WAIT_DONE cycles rsp_val=1, rsp_err=1, rsp_c_data=0.
REQ-027 Reset mid-job: rst pulsed in WAIT_DONE -> all outputs 0 the same cycle, no rsp_val, and the next job is accepted normally.
